// File: rtl/rr_mux_arbiter_pkg.sv
// Shared definitions for the round-robin mux arbiter and its request picker.
package rr_mux_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

endpackage

// File: rtl/rr_mux_arbiter_pick4.sv
// Round-robin picker: first set request bit after i_last, searching upward modulo 4.
module rr_pick4
  import rr_mux_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [SEL_W-1:0]   i_last,
  output logic               o_found,
  output logic [SEL_W-1:0]   o_winner
);

  logic [SEL_W-1:0] w_idx;

  // Walk from the farthest offset to the nearest so the nearest set bit wins.
  always_comb begin
    o_found  = |i_req;
    o_winner = '0;
    w_idx    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_idx = i_last + SEL_W'(k);
      if (i_req[w_idx]) o_winner = w_idx;
    end
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one 4:1 data mux among four requesters,
// with a valid/ready output and a fairness hold limit per grant.
module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         req,
  input  logic [WIDTH-1:0]   d0,
  input  logic [WIDTH-1:0]   d1,
  input  logic [WIDTH-1:0]   d2,
  input  logic [WIDTH-1:0]   d3,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [1:0]         sel,
  output logic [3:0]         gnt,
  output logic               busy
);

  state_t              r_state, w_nxt_state;
  logic [SEL_W-1:0]    r_sel, w_nxt_sel;
  logic [SEL_W-1:0]    r_last, w_nxt_last;
  logic [NUM_REQ-1:0]  r_gnt, w_nxt_gnt;
  logic [HOLD_W-1:0]   r_hold, w_nxt_hold;
  logic                w_found;
  logic [SEL_W-1:0]    w_win;
  logic                w_xfer;
  logic                w_at_limit;
  logic                w_others;
  logic                w_release;

  rr_pick4 u_pick (
    .i_req    (req),
    .i_last   (r_last),
    .o_found  (w_found),
    .o_winner (w_win)
  );

  assign busy      = (r_state == ST_BUSY);
  assign sel       = r_sel;
  assign gnt       = r_gnt;
  assign out_valid = busy && req[r_sel];

  always_comb begin
    case (r_sel)
      2'd0:    out_data = d0;
      2'd1:    out_data = d1;
      2'd2:    out_data = d2;
      default: out_data = d3;
    endcase
  end

  assign w_xfer     = out_valid && out_ready;
  assign w_at_limit = (r_hold == HOLD_W'(MAX_HOLD - 1));
  assign w_others   = |(req & ~r_gnt);
  // A dropped request releases even without a transfer; the hold limit only
  // releases when someone else is actually waiting.
  assign w_release  = !req[r_sel] || (w_xfer && w_at_limit && w_others);

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_sel   = r_sel;
    w_nxt_last  = r_last;
    w_nxt_gnt   = r_gnt;
    w_nxt_hold  = r_hold;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_nxt_state = ST_BUSY;
          w_nxt_sel   = w_win;
          w_nxt_gnt   = NUM_REQ'(1) << w_win;
          w_nxt_hold  = '0;
        end
      end
      default: begin
        if (w_release) begin
          w_nxt_state = ST_IDLE;
          w_nxt_last  = r_sel;
          w_nxt_gnt   = '0;
          w_nxt_sel   = '0;
          w_nxt_hold  = '0;
        end else if (w_xfer) begin
          if (w_at_limit)          w_nxt_hold = '0;
          else if (r_hold != '1)   w_nxt_hold = r_hold + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_sel   <= '0;
      r_last  <= 2'd3;
      r_gnt   <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_sel   <= w_nxt_sel;
      r_last  <= w_nxt_last;
      r_gnt   <= w_nxt_gnt;
      r_hold  <= w_nxt_hold;
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter: rotation, hold limit, backpressure, drop and async reset.
module tb_rr_mux_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] d0, d1, d2, d3;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic [1:0]  sel;
  logic [3:0]  gnt;
  logic        busy;

  int vectors;
  int miscompares;
  logic [31:0] dv [4];

  rr_mux_arbiter #(.WIDTH(32), .MAX_HOLD(8), .HOLD_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .d0        (d0),
    .d1        (d1),
    .d2        (d2),
    .d3        (d3),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .sel       (sel),
    .gnt       (gnt),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_idle(input string tag);
    #1;
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".gnt"}, 32'(gnt), 32'd0);
    chk({tag, ".vld"}, 32'(out_valid), 32'd0);
  endtask

  task automatic chk_gnt(input string tag, input int r, input logic v);
    logic [3:0] g;
    #1;
    g = 4'd1 << r;
    chk({tag, ".gnt"}, 32'(gnt), 32'(g));
    chk({tag, ".sel"}, 32'(sel), 32'(r));
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    chk({tag, ".vld"}, 32'(out_valid), 32'(v));
    if (v) chk({tag, ".data"}, out_data, dv[r]);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    dv[0] = 32'hA5A5_0000;
    dv[1] = 32'h1111_1111;
    dv[2] = 32'h2222_2222;
    dv[3] = 32'h3333_3333;
    d0 = dv[0]; d1 = dv[1]; d2 = dv[2]; d3 = dv[3];
    req = 4'b0000;
    out_ready = 1'b0;
    rst_n = 1'b0;
    #2;
    chk_idle("reset");
    chk("reset.sel", 32'(sel), 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Single requester streams past the hold limit without bubbles.
    req = 4'b0001;
    out_ready = 1'b1;
    chk_idle("solo.pre");
    step();
    for (int i = 0; i < 12; i++) begin
      chk_gnt($sformatf("solo.beat%0d", i), 0, 1'b1);
      step();
    end

    // Full rotation from reset: 0,1,2,3,0 with 8 beats each and one bubble.
    req = 4'b0000;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    req = 4'b1111;
    step();
    for (int g = 0; g < 5; g++) begin
      for (int b = 0; b < 8; b++) begin
        chk_gnt($sformatf("rot.g%0d.b%0d", g, b), g % 4, 1'b1);
        step();
      end
      chk_idle($sformatf("rot.bubble%0d", g));
      if (g < 4) step();
    end

    // Grant requester 1 briefly to set last=1, then backpressure on requester 2.
    req = 4'b0010;
    step();
    chk_gnt("setlast", 1, 1'b1);
    req = 4'b0000;
    step();
    chk_idle("setlast.rel");
    req = 4'b0110;
    out_ready = 1'b0;
    step();
    for (int i = 0; i < 20; i++) begin
      chk_gnt($sformatf("bp.stall%0d", i), 2, 1'b1);
      step();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk_gnt($sformatf("bp.beat%0d", i), 2, 1'b1);
      step();
    end
    chk_idle("bp.rel");
    step();

    // Requester 1 drops after 3 beats while requester 3 waits.
    req = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      chk_gnt($sformatf("drop.beat%0d", i), 1, 1'b1);
      step();
    end
    req = 4'b1000;
    chk_gnt("drop.now", 1, 1'b0);
    step();
    chk_idle("drop.bubble");
    step();
    chk_gnt("drop.next", 3, 1'b1);

    // Async reset while requester 2 holds the grant.
    req = 4'b0100;
    step();
    chk_idle("ar.bubble");
    step();
    chk_gnt("ar.pre", 2, 1'b1);
    rst_n = 1'b0;
    chk_idle("ar.async");
    req = 4'b0101;
    rst_n = 1'b1;
    step();
    chk_gnt("ar.after", 0, 1'b1);

    // last=3 after reset: 1010 gives 1, then 3 at the next arbitration.
    req = 4'b0000;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    req = 4'b1010;
    step();
    for (int b = 0; b < 8; b++) begin
      chk_gnt($sformatf("alt.r1.b%0d", b), 1, 1'b1);
      step();
    end
    chk_idle("alt.bubble");
    step();
    chk_gnt("alt.r3", 3, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
